// File: rtl/chunked_addsub_pkg.sv
// ============================================================================
// Module  : addsub_pkg
// Brief   : Shared state encodings and default sizing for chunked_addsub.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package addsub_pkg;

  localparam int c_def_width = 16;
  localparam int c_def_chunk = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Chunk index width; kept at least one bit so NCH = 1 still elaborates.
  function automatic int idx_width(input int nch);
    return (nch > 1) ? $clog2(nch) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/chunked_addsub_if.sv
// ============================================================================
// Module  : chunked_addsub_if
// Brief   : Operand/result valid-ready bundle for the chunked adder/subtractor.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface chunked_addsub_if
  import addsub_pkg::*;
#(
  parameter int WIDTH = c_def_width
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             SUB;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] R;
  logic             COUT;
  logic             OVF;
  logic             ZERO;

  modport master (
    output in_valid, A, B, SUB, out_ready,
    input  in_ready, out_valid, R, COUT, OVF, ZERO
  );

  modport slave (
    input  in_valid, A, B, SUB, out_ready,
    output in_ready, out_valid, R, COUT, OVF, ZERO
  );

endinterface

`default_nettype wire

// File: rtl/chunked_addsub_ripple_slice.sv
// ============================================================================
// Module  : ripple_slice (with FullAdder cell)
// Brief   : CHUNK-bit ripple-carry slice; also exposes the carry into its MSB.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module FullAdder (
  input  wire logic a,
  input  wire logic b,
  input  wire logic cin,
  output logic      s,
  output logic      cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

module ripple_slice
  import addsub_pkg::*;
#(
  parameter int CHUNK = c_def_chunk
) (
  input  wire logic [CHUNK-1:0] a,
  input  wire logic [CHUNK-1:0] b,
  input  wire logic             cin,
  output logic      [CHUNK-1:0] s,
  output logic                  cout,
  output logic                  c_msb
);

  logic [CHUNK:0] w_c;

  assign w_c[0] = cin;

  for (genvar gi = 0; gi < CHUNK; gi++) begin : g_bit
    FullAdder u_fa (
      .a    (a[gi]),
      .b    (b[gi]),
      .cin  (w_c[gi]),
      .s    (s[gi]),
      .cout (w_c[gi+1])
    );
  end

  assign cout  = w_c[CHUNK];
  assign c_msb = w_c[CHUNK-1];

endmodule

`default_nettype wire

// File: rtl/chunked_addsub.sv
// ============================================================================
// Module  : chunked_addsub
// Brief   : Multi-cycle WIDTH-bit add/subtract, CHUNK bits per clock, with
//           carry/overflow/zero flags. Define CHUNKED_ADDSUB_SAT_EN for
//           signed saturation on overflow.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module chunked_addsub
  import addsub_pkg::*;
#(
  parameter int WIDTH = c_def_width,
  parameter int CHUNK = c_def_chunk
) (
  input wire logic        clk,
  input wire logic        rst_n,
  chunked_addsub_if.slave bus
);

  localparam int NCH  = WIDTH / CHUNK;
  localparam int IDXW = idx_width(NCH);
  localparam logic [IDXW-1:0] c_last_idx = IDXW'(NCH - 1);

  state_t            r_state;
  logic [IDXW-1:0]   r_idx;
  logic [WIDTH-1:0]  r_a;
  logic [WIDTH-1:0]  r_b;
  logic              r_carry;
  logic [WIDTH-1:0]  r_acc;
  logic [WIDTH-1:0]  r_r;
  logic              r_cout;
  logic              r_ovf;
  logic              r_zero;
  logic              r_in_ready;
  logic              r_out_valid;

  int                w_base;
  logic [CHUNK-1:0]  w_a_sl;
  logic [CHUNK-1:0]  w_b_sl;
  logic [CHUNK-1:0]  w_sum;
  logic              w_cout;
  logic              w_cmsb;
  logic              w_ovf;
  logic [WIDTH-1:0]  w_acc_next;
  logic [WIDTH-1:0]  w_result;

  always_comb begin
    w_base = int'(r_idx) * CHUNK;
    w_a_sl = r_a[w_base +: CHUNK];
    w_b_sl = r_b[w_base +: CHUNK];
  end

  ripple_slice #(
    .CHUNK (CHUNK)
  ) u_slice (
    .a     (w_a_sl),
    .b     (w_b_sl),
    .cin   (r_carry),
    .s     (w_sum),
    .cout  (w_cout),
    .c_msb (w_cmsb)
  );

  // Overflow is only meaningful on the last slice, where the slice MSB is the word MSB.
  always_comb begin
    w_ovf                       = w_cmsb ^ w_cout;
    w_acc_next                  = r_acc;
    w_acc_next[w_base +: CHUNK] = w_sum;
    w_result                    = w_acc_next;
`ifdef CHUNKED_ADDSUB_SAT_EN
    if (w_ovf) begin
      w_result = r_a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                              : {1'b0, {(WIDTH-1){1'b1}}};
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_idx       <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_carry     <= 1'b0;
      r_acc       <= '0;
      r_r         <= '0;
      r_cout      <= 1'b0;
      r_ovf       <= 1'b0;
      r_zero      <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.in_valid && r_in_ready) begin
            r_a        <= bus.A;
            r_b        <= bus.B ^ {WIDTH{bus.SUB}};
            r_carry    <= bus.SUB;
            r_idx      <= '0;
            r_in_ready <= 1'b0;
            r_state    <= ST_RUN;
          end
        end
        ST_RUN: begin
          r_acc   <= w_acc_next;
          r_carry <= w_cout;
          r_idx   <= r_idx + IDXW'(1);
          if (r_idx == c_last_idx) begin
            r_idx       <= '0;
            r_r         <= w_result;
            r_cout      <= w_cout;
            r_ovf       <= w_ovf;
            r_zero      <= (w_result == '0);
            r_out_valid <= 1'b1;
            r_state     <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_carry     <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
          r_state     <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.R         = r_r;
  assign bus.COUT      = r_cout;
  assign bus.OVF       = r_ovf;
  assign bus.ZERO      = r_zero;

endmodule

`default_nettype wire
